bundle_packer: RTL and testbench

Upstream feeder for the element-select stage. Accepts a byte stream over a valid/ready handshake and packs consecutive beats into a NUM_ELEM-entry array bundle (element 0 = first beat). When the bundle is complete, or closed early by a last marker, it is presented downstream with its own valid/ready handshake. A per-element valid mask and fill count go with the bundle. The packer can accept the first beat of the next bundle in the same cycle the current bundle is consumed.

---
 rtl/bundle_pkg.sv | 17 +
 rtl/bundle_packer.sv | 109 ++++++++++
 tb/tb_bundle_packer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bundle_pkg.sv
// Shared types for the bundle packer and element-select stage.
// Element width, bundle depth, index widths and packer states.
package bundle_pkg;

  localparam int ELEM_W   = 8;
  localparam int NUM_ELEM = 4;
  localparam int IDX_W    = $clog2(NUM_ELEM);
  localparam int CNT_W    = IDX_W + 1;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/bundle_packer.sv
// Packs a valid/ready byte stream into NUM_ELEM-entry bundles.
// Ports: in_* beat handshake, bundle_* out handshake, mask, count.
module bundle_packer
  import bundle_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  elem_t            in_data_i,
  input  logic             in_last_i,
  output logic             bundle_valid_o,
  input  logic             bundle_ready_i,
  output elem_t            data_bundle_o [NUM_ELEM-1:0],
  output logic [NUM_ELEM-1:0] elem_valid_o,
  output logic [CNT_W-1:0] fill_count_o
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_ELEM - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  elem_t                data_q [NUM_ELEM-1:0];
  elem_t                data_d [NUM_ELEM-1:0];
  logic [NUM_ELEM-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]     fill_q, fill_d;
  logic                 accept;

  // While full, a beat may enter only in the cycle the
  // bundle leaves, so ready mirrors the downstream ready.
  assign in_ready_o = (state_q == FILL) ? 1'b1
                                        : bundle_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  assign bundle_valid_o = (state_q == FULL);
  assign data_bundle_o  = data_q;
  assign elem_valid_o   = valid_q;
  assign fill_count_o   = fill_q;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fill_d   = fill_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          data_d[wr_idx_q]  = in_data_i;
          valid_d[wr_idx_q] = 1'b1;
          fill_d            = fill_q + CNT_W'(1);
          if (in_last_i || wr_idx_q == LAST_IDX) begin
            state_d  = FULL;
            wr_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (bundle_ready_i) begin
          for (int k = 0; k < NUM_ELEM; k++) begin
            data_d[k] = '0;
          end
          valid_d  = '0;
          fill_d   = '0;
          state_d  = FILL;
          wr_idx_d = '0;
          // Overlapped beat seeds the next bundle.
          if (accept) begin
            data_d[0]  = in_data_i;
            valid_d[0] = 1'b1;
            fill_d     = CNT_W'(1);
            if (in_last_i) begin
              state_d = FULL;
            end else begin
              wr_idx_d = IDX_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= FILL;
      wr_idx_q <= '0;
      valid_q  <= '0;
      fill_q   <= '0;
      for (int k = 0; k < NUM_ELEM; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      valid_q  <= valid_d;
      fill_q   <= fill_d;
      for (int k = 0; k < NUM_ELEM; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

endmodule

// File: tb/tb_bundle_packer.sv
// Directed self-checking bench for bundle_packer.
// Hand-computed bundles, masks and counts per scenario.
module tb_bundle_packer;
  import bundle_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                in_valid_i;
  logic                in_ready_o;
  elem_t               in_data_i;
  logic                in_last_i;
  logic                bundle_valid_o;
  logic                bundle_ready_i;
  elem_t               data_bundle_o [NUM_ELEM-1:0];
  logic [NUM_ELEM-1:0] elem_valid_o;
  logic [CNT_W-1:0]    fill_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  bundle_packer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .in_last_i      (in_last_i),
    .bundle_valid_o (bundle_valid_o),
    .bundle_ready_i (bundle_ready_i),
    .data_bundle_o  (data_bundle_o),
    .elem_valid_o   (elem_valid_o),
    .fill_count_o   (fill_count_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk();
    return {data_bundle_o[3], data_bundle_o[2],
            data_bundle_o[1], data_bundle_o[0]};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [7:0] d,
                      input logic l);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    tick();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    in_data_i  = 8'hEE;
  endtask

  task automatic chk_bundle(input string tag,
                            input logic v,
                            input logic [31:0] d,
                            input logic [3:0] m,
                            input logic [2:0] c);
    check({tag, ".valid"}, 32'(bundle_valid_o), 32'(v));
    check({tag, ".data"},  pk(), d);
    check({tag, ".mask"},  32'(elem_valid_o), 32'(m));
    check({tag, ".count"}, 32'(fill_count_o), 32'(c));
  endtask

  task automatic consume();
    bundle_ready_i = 1'b1;
    tick();
    bundle_ready_i = 1'b0;
  endtask

  initial begin
    rst_ni         = 1'b0;
    in_valid_i     = 1'b0;
    in_data_i      = '0;
    in_last_i      = 1'b0;
    bundle_ready_i = 1'b0;
    tick();
    tick();
    chk_bundle("rst", 1'b0, 32'h0, 4'b0000, 3'd0);
    check("rst.in_ready", 32'(in_ready_o), 32'd1);
    rst_ni = 1'b1;
    tick();

    // four beats, downstream stalled
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    chk_bundle("fill3", 1'b0, 32'h00332211,
               4'b0111, 3'd3);
    beat(8'h44, 1'b0);
    chk_bundle("full4", 1'b1, 32'h44332211,
               4'b1111, 3'd4);
    check("full4.in_ready", 32'(in_ready_o), 32'd0);

    // stall with upstream pushing
    in_valid_i = 1'b1;
    in_data_i  = 8'h99;
    in_last_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_bundle("stall", 1'b1, 32'h44332211,
                 4'b1111, 3'd4);
      check("stall.in_ready", 32'(in_ready_o), 32'd0);
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    consume();
    chk_bundle("drain1", 1'b0, 32'h0, 4'b0000, 3'd0);

    // early close by last marker
    beat(8'hA5, 1'b0);
    beat(8'h5A, 1'b1);
    chk_bundle("last2", 1'b1, 32'h00005AA5,
               4'b0011, 3'd2);

    // overlapped consume + single-beat last bundle
    bundle_ready_i = 1'b1;
    beat(8'h77, 1'b1);
    bundle_ready_i = 1'b0;
    chk_bundle("ovl1", 1'b1, 32'h00000077,
               4'b0001, 3'd1);
    consume();
    chk_bundle("drain2", 1'b0, 32'h0, 4'b0000, 3'd0);

    // streaming 8 beats with ready held
    bundle_ready_i = 1'b1;
    in_valid_i     = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data_i = 8'(i);
      #1;
      check("stream.in_ready", 32'(in_ready_o), 32'd1);
      tick();
      if (i == 4)
        chk_bundle("stream_b0", 1'b1, 32'h04030201,
                   4'b1111, 3'd4);
      if (i == 5)
        chk_bundle("stream_b1s", 1'b0, 32'h00000005,
                   4'b0001, 3'd1);
      if (i == 8)
        chk_bundle("stream_b1", 1'b1, 32'h08070605,
                   4'b1111, 3'd4);
    end
    in_valid_i = 1'b0;
    tick();
    bundle_ready_i = 1'b0;
    chk_bundle("drain3", 1'b0, 32'h0, 4'b0000, 3'd0);

    // last on 4th beat equals a normal full bundle
    beat(8'h0A, 1'b0);
    beat(8'h0B, 1'b0);
    beat(8'h0C, 1'b0);
    beat(8'h0D, 1'b1);
    chk_bundle("last4", 1'b1, 32'h0D0C0B0A,
               4'b1111, 3'd4);
    consume();

    // reset discards a partial bundle
    beat(8'hB1, 1'b0);
    beat(8'hB2, 1'b0);
    rst_ni = 1'b0;
    tick();
    chk_bundle("midrst", 1'b0, 32'h0, 4'b0000, 3'd0);
    check("midrst.in_ready", 32'(in_ready_o), 32'd1);
    rst_ni = 1'b1;
    beat(8'hC1, 1'b0);
    beat(8'hC2, 1'b0);
    beat(8'hC3, 1'b0);
    beat(8'hC4, 1'b0);
    chk_bundle("postrst", 1'b1, 32'hC4C3C2C1,
               4'b1111, 3'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
